// File: rtl/seq_sort_pkg.sv
// Shared types and constants for the sequential sort engine.
// sort_cycles gives the fixed length of the bubble-sort phase for an L-word frame.
package seq_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 8;

  function automatic int sort_cycles(input int l);
    return (l * (l - 1)) / 2;
  endfunction

endpackage

// File: rtl/seq_sort_engine_cmp_swap.sv
// Combinational unsigned compare-exchange: orders a pair into (min, max).
// This is the only comparator in the engine; the sequencer time-shares it.
module cmp_swap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  // Strict compare keeps equal words in place, which makes the sort stable.
  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/seq_sort_engine.sv
// Frame buffer plus sequencer: load up to DEPTH words, bubble-sort them in place
// with one shared compare-exchange, then stream the ascending frame out.
module seq_sort_engine
  import seq_sort_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int IDX_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [IDX_W-1:0] out_len,
  output logic             busy
);

  localparam int AW = IDX_W - 1;
  localparam int SW = 2 * IDX_W;
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO       = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] wr, rd, k, j, len;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;
  logic             do_swap;
  logic [AW-1:0]    ja, jb;
  logic             in_fire, out_fire, close, pass_end, sort_done;
  logic [SW-1:0]    sort_cnt;

  assign ja    = j[AW-1:0];
  assign jb    = ja + AW'(1);
  assign cmp_a = mem[ja];
  assign cmp_b = mem[jb];

  cmp_swap #(.WIDTH(WIDTH)) u_cmp (
    .a    (cmp_a),
    .b    (cmp_b),
    .lo   (cmp_lo),
    .hi   (cmp_hi),
    .swap (do_swap)
  );

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
  assign out_data  = mem[rd[AW-1:0]];
  assign out_last  = out_valid && (rd == len - ONE);
  assign out_len   = len;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // A full buffer closes the frame even without in_last.
  assign close     = in_fire && (in_last || (wr == LAST_SLOT));
  assign pass_end  = (j == len - k - TWO);
  assign sort_done = pass_end && (k == len - TWO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (close) state_nxt = (wr == '0) ? DRAIN : SORT;
      SORT:    if (sort_done) state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr  <= '0;
      rd  <= '0;
      k   <= '0;
      j   <= '0;
      len <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (close) begin
              len <= wr + ONE;
              wr  <= '0;
              rd  <= '0;
              k   <= '0;
              j   <= '0;
            end else begin
              wr <= wr + ONE;
            end
          end
        end
        // Pass k walks j over 0..L-2-k; no early exit keeps latency fixed.
        SORT: begin
          if (pass_end) begin
            j <= '0;
            k <= k + ONE;
          end else begin
            j <= j + ONE;
          end
        end
        DRAIN: begin
          if (out_fire) rd <= out_last ? '0 : rd + ONE;
        end
        default: ;
      endcase
    end
  end

  // Buffer holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr[AW-1:0]] <= in_data;
    end else if (state == SORT && do_swap) begin
      mem[ja] <= cmp_lo;
      mem[jb] <= cmp_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                sort_cnt <= '0;
    else if (state == SORT) sort_cnt <= sort_cnt + SW'(1);
    else                    sort_cnt <= '0;
  end

  always @(posedge clk) begin
    if (!rst && state == SORT && sort_done)
      assert (int'(sort_cnt) + 1 == sort_cycles(int'(len)));
  end

endmodule

// File: tb/tb_seq_sort_engine.sv
// Randomised and directed bench for seq_sort_engine against a queue-sort reference.
module tb_seq_sort_engine;
  import seq_sort_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDX_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [IDX_W-1:0] out_len;
  logic             busy;

  seq_sort_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_len   (out_len),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] expq[$];
  logic [WIDTH-1:0] rxq[$];
  bit               rxl[$];
  int               acc_cyc, vld_cyc, stall_err, first_len;
  bit               tmo;

  // All helpers start and end 1 time unit after a rising edge.
  task automatic send_frame(input bit mark_last);
    bit acc;
    int t;
    for (int i = 0; i < txq.size(); i++) begin
      in_valid = 1'b1;
      in_data  = txq[i];
      in_last  = mark_last && (i == txq.size() - 1);
      t = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 100);
      if (!acc) tmo = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    vld_cyc = cyc;
    if (!out_valid) tmo = 1'b1;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1 then 1, 2: random ready
  task automatic drain(input int mode);
    bit [0:5]         pat;
    logic [WIDTH-1:0] pd;
    bit               pl, pstall, done;
    int               c;
    pat = 6'b100101;
    rxq.delete();
    rxl.delete();
    stall_err = 0;
    first_len = -1;
    pstall = 1'b0;
    done = 1'b0;
    pd = '0;
    pl = 1'b0;
    c = 0;
    while (!done && c < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c < 6) ? pat[c] : 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid) begin
        if (first_len < 0) first_len = int'(out_len);
        if (pstall && (out_data !== pd || out_last !== pl)) stall_err++;
        if (out_ready) begin
          rxq.push_back(out_data);
          rxl.push_back(out_last);
          if (out_last) done = 1'b1;
        end
        pstall = !out_ready;
        pd = out_data;
        pl = out_last;
      end
      @(posedge clk);
      #1;
      c++;
    end
    out_ready = 1'b0;
    if (!done) tmo = 1'b1;
  endtask

  task automatic make_expected();
    expq = txq;
    expq.sort();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (out_len !== '0) $display("FAIL reset_out_len: got %0d want 0", out_len); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    tmo = 1'b0;
    txq = '{32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
    make_expected();
    send_frame(1'b1);
    n_chk++; if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy); else n_pass++;
    wait_valid();
    n_chk++; if (vld_cyc - acc_cyc !== sort_cycles(8)) $display("FAIL full_latency: got %0d want %0d", vld_cyc - acc_cyc, sort_cycles(8)); else n_pass++;
    drain(0);
    n_chk++; if (first_len !== 8) $display("FAIL full_len: got %0d want 8", first_len); else n_pass++;
    n_chk++; if (rxq.size() !== 8) $display("FAIL full_count: got %0d want 8", rxq.size()); else n_pass++;
    for (int i = 0; i < rxq.size() && i < 8; i++) begin
      n_chk++; if (rxq[i] !== expq[i]) $display("FAIL full_data[%0d]: got %0h want %0h", i, rxq[i], expq[i]); else n_pass++;
      n_chk++; if (rxl[i] !== (i == 7)) $display("FAIL full_last[%0d]: got %b want %b", i, rxl[i], i == 7); else n_pass++;
    end
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL full_return: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_single();
    tmo = 1'b0;
    txq = '{32'hDEADBEEF};
    send_frame(1'b1);
    wait_valid();
    n_chk++; if (vld_cyc - acc_cyc !== 0) $display("FAIL single_latency: got %0d want 0", vld_cyc - acc_cyc); else n_pass++;
    drain(0);
    n_chk++; if (rxq.size() !== 1) $display("FAIL single_count: got %0d want 1", rxq.size()); else n_pass++;
    if (rxq.size() > 0) begin
      n_chk++; if (rxq[0] !== 32'hDEADBEEF) $display("FAIL single_data: got %0h want deadbeef", rxq[0]); else n_pass++;
      n_chk++; if (rxl[0] !== 1'b1) $display("FAIL single_last: got %b want 1", rxl[0]); else n_pass++;
    end
    n_chk++; if (first_len !== 1) $display("FAIL single_len: got %0d want 1", first_len); else n_pass++;
  endtask

  task automatic test_extremes();
    tmo = 1'b0;
    txq = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF};
    expq = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    send_frame(1'b1);
    wait_valid();
    n_chk++; if (vld_cyc - acc_cyc !== 6) $display("FAIL ext_latency: got %0d want 6", vld_cyc - acc_cyc); else n_pass++;
    drain(0);
    n_chk++; if (rxq.size() !== 4) $display("FAIL ext_count: got %0d want 4", rxq.size()); else n_pass++;
    for (int i = 0; i < rxq.size() && i < 4; i++) begin
      n_chk++; if (rxq[i] !== expq[i]) $display("FAIL ext_data[%0d]: got %0h want %0h", i, rxq[i], expq[i]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    tmo = 1'b0;
    txq = '{32'd3, 32'd3, 32'd1};
    expq = '{32'd1, 32'd3, 32'd3};
    send_frame(1'b1);
    wait_valid();
    drain(1);
    n_chk++; if (stall_err !== 0) $display("FAIL stall_hold: got %0d changes want 0", stall_err); else n_pass++;
    n_chk++; if (rxq.size() !== 3) $display("FAIL stall_count: got %0d want 3", rxq.size()); else n_pass++;
    for (int i = 0; i < rxq.size() && i < 3; i++) begin
      n_chk++; if (rxq[i] !== expq[i]) $display("FAIL stall_data[%0d]: got %0d want %0d", i, rxq[i], expq[i]); else n_pass++;
      n_chk++; if (rxl[i] !== (i == 2)) $display("FAIL stall_last[%0d]: got %b want %b", i, rxl[i], i == 2); else n_pass++;
    end
  endtask

  task automatic test_no_last();
    tmo = 1'b0;
    txq = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    make_expected();
    send_frame(1'b0);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL nolast_in_ready: got %b want 0", in_ready); else n_pass++;
    wait_valid();
    drain(0);
    n_chk++; if (rxq.size() !== 8) $display("FAIL nolast_count: got %0d want 8", rxq.size()); else n_pass++;
    for (int i = 0; i < rxq.size() && i < 8; i++) begin
      n_chk++; if (rxq[i] !== expq[i] || rxl[i] !== (i == 7)) $display("FAIL nolast_beat[%0d]: got %0d/%b want %0d/%b", i, rxq[i], rxl[i], expq[i], i == 7); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sort();
    int stale;
    tmo = 1'b0;
    txq = '{32'd9, 32'd4, 32'd6, 32'd2, 32'd8, 32'd1};
    send_frame(1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_async: got busy=%b ready=%b want 0/1", busy, in_ready); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stale++;
      @(posedge clk);
      #1;
    end
    n_chk++; if (stale !== 0) $display("FAIL rst_stale: got %0d valid cycles want 0", stale); else n_pass++;
    txq = '{32'd2, 32'd1};
    send_frame(1'b1);
    wait_valid();
    drain(0);
    n_chk++; if (rxq.size() !== 2) $display("FAIL rst_next_count: got %0d want 2", rxq.size()); else n_pass++;
    if (rxq.size() == 2) begin
      n_chk++; if (rxq[0] !== 32'd1 || rxq[1] !== 32'd2) $display("FAIL rst_next_data: got %0d,%0d want 1,2", rxq[0], rxq[1]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int  len;
    bit  ml;
    for (int f = 0; f < 8; f++) begin
      tmo = 1'b0;
      len = $urandom_range(1, DEPTH);
      txq.delete();
      for (int i = 0; i < len; i++)
        txq.push_back((f % 2 == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom));
      ml = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      make_expected();
      send_frame(ml);
      wait_valid();
      n_chk++; if (vld_cyc - acc_cyc !== sort_cycles(len)) $display("FAIL rand%0d_latency: got %0d want %0d", f, vld_cyc - acc_cyc, sort_cycles(len)); else n_pass++;
      drain(2);
      n_chk++; if (first_len !== len) $display("FAIL rand%0d_len: got %0d want %0d", f, first_len, len); else n_pass++;
      n_chk++; if (stall_err !== 0) $display("FAIL rand%0d_hold: got %0d changes want 0", f, stall_err); else n_pass++;
      n_chk++; if (rxq.size() !== len) $display("FAIL rand%0d_count: got %0d want %0d", f, rxq.size(), len); else n_pass++;
      for (int i = 0; i < rxq.size() && i < len; i++) begin
        n_chk++; if (rxq[i] !== expq[i] || rxl[i] !== (i == len - 1)) $display("FAIL rand%0d_beat[%0d]: got %0h/%b want %0h/%b", f, i, rxq[i], rxl[i], expq[i], i == len - 1); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_single();
    test_extremes();
    test_stall();
    test_no_last();
    test_reset_mid_sort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
